mem_master: RTL and testbench
=============================

Name: mem_master

Overview:
- Initiator side of the coprocessor word memory.
- Accepts single-block read or write requests from the compute core over a valid/ready channel and drives the memory's address, data and strobe pins, including the status write port.
- Returns a response per request: read data, or a write acknowledge.
- Rejects out-of-range accesses and writes that would clobber the config/status words.

Parameters:
- size, 1024, number of memory cells
- blocks, 4, cells per block transfer
- log_size, 10, address width
- cell_width, 32, bits per cell
- width, blocks*cell_width, block data width

Ports:
- in_clk  input  1  clock; all logic on rising edge
- in_reset  input  1  asynchronous active-low reset
- in_req_valid  input  1  core request valid
- out_req_ready  output  1  high only in IDLE
- in_req_write  input  1  1=block write, 0=block read
- in_req_address  input  log_size  base cell address
- in_req_data  input  width  write block
- out_resp_valid  output  1  response valid
- in_resp_ready  input  1  core accepts response
- out_resp_data  output  width  read block; 0 for writes and errors
- out_resp_err  output  1  request rejected
- out_mem_address  output  log_size  memory address
- out_mem_data  output  width  memory write data
- out_mem_read_en  output  1  memory read strobe
- out_mem_write_en  output  1  memory write strobe
- in_mem_data  input  width  memory read data (registered, 1-cycle latency, 'bz when not reading)
- out_mem_status  output  cell_width  status word to memory
- out_mem_write_status_en  output  1  status write strobe

Behaviour:
- Reset (async, in_reset=0):
  - state=IDLE.
  - All outputs 0 except out_req_ready=1.
  - Any in-flight transaction is discarded; no strobe may be asserted during or after reset.
- States: IDLE, READ, CAPTURE, WRITE, STATUS (only with the optional feature), RESP.
- IDLE:
  - out_req_ready=1.
  - On in_req_valid, latch write flag, address and data.
  - Range check: address+blocks > size, computed in log_size+1 bits, sets the error.
  - Write check: a write with address < 2 (reserved config/status words) sets the error.
  - Next state: error -> RESP (or STATUS if enabled); write -> WRITE; read -> READ.
- READ:
  - One cycle with out_mem_read_en=1 and out_mem_address=latched address.
  - -> CAPTURE.
- CAPTURE:
  - Sample in_mem_data into the response register.
  - -> STATUS if enabled, else RESP.
  - in_mem_data is never sampled in any other state.
- WRITE:
  - One cycle with out_mem_write_en=1 and out_mem_address/out_mem_data driven.
  - -> STATUS if enabled, else RESP.
- RESP:
  - out_resp_valid=1; data and err are held stable until in_resp_ready=1.
  - On in_resp_ready=1, go to IDLE.
- Strobe rules:
  - out_mem_read_en and out_mem_write_en are never high together, and each is high for exactly one cycle per transaction.
  - out_mem_address and out_mem_data are 0 when no strobe is asserted.
- Latency, counted from the accepting edge N:
  - Read: out_resp_valid visible after edge N+2.
  - Write: visible after edge N+1.
  - Error: visible after edge N.
  - Each adds +1 with the optional feature.
- No pipelining: one outstanding transaction; a new request is accepted at the earliest one cycle after the response handshake.
- in_req_valid held across the RESP->IDLE transition is accepted on the IDLE cycle.
- Boundary cases:
  - Address = size-blocks (1020) is legal.
  - Address 1021 is an error.
  - Reads of addresses 0/1 are legal.

Optional Feature:
- Macro: MEM_MASTER_STATUS_UPDATE_EN.
- When defined:
  - The STATUS state is inserted before RESP for every transaction, including errors.
  - It drives out_mem_write_status_en=1 for one cycle.
  - out_mem_status = {txn_count[15:0], 14'b0, err, 1'b1}.
  - txn_count is a 16-bit counter, incremented at STATUS, that wraps 0xFFFF->0 and is reset to 0.
- When undefined: no STATUS state, out_mem_write_status_en and out_mem_status are tied to 0, and no counter exists.

Decomposition:
- Package coproc_mem_pkg:
  - state encoding constants
  - RESERVED_WORDS=2
  - status bit positions: DONE=0, ERR=1, COUNT_LSB=16
- Sub-module mem_addr_check (combinational):
  - Inputs: address, write flag.
  - Output: err.
  - Parameterised on size/blocks/log_size.

Test Plan:
- Reset mid-read:
  - Stimulus: assert in_reset=0 in the READ cycle.
  - Response: all strobes 0 immediately, out_req_ready=1 after release, no response issued.
- Write then read:
  - Stimulus: write address 8, data 0x4444_4444_3333_3333_2222_2222_1111_1111; then read address 8.
  - Response: write ack err=0 after N+1; read out_resp_data equals the written block after N+2; mem_write_en high exactly one cycle.
- Range boundaries:
  - Read at address 1020 -> err=0.
  - Read at address 1021 -> err=1, no read strobe, out_resp_data=0.
- Reserved-word write:
  - Write at address 1 -> err=1, no write strobe.
  - Read at address 0 -> err=0.
- Response backpressure:
  - Stimulus: hold in_resp_ready=0 for 5 cycles.
  - Response: out_resp_valid and data stable, out_req_ready=0, second in_req_valid ignored until handshake.
- With MEM_MASTER_STATUS_UPDATE_EN:
  - Stimulus: three transactions, the third an error.
  - Response: status writes 0x0001_0001, 0x0002_0001, 0x0003_0003, each one-cycle strobes before the corresponding RESP.

Source files
------------

// File: rtl/coproc_mem_pkg.sv
// Shared definitions for the coprocessor word-memory initiator.
//   state_t           : FSM state encoding
//   RESERVED_WORDS    : cells 0..RESERVED_WORDS-1 hold config/status and are write-protected
//   STATUS_*          : bit positions inside the status word written back to memory
//   build_status()    : assembles the status word from a transaction count and error flag
package coproc_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_STATUS  = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    localparam int unsigned RESERVED_WORDS   = 2;
    localparam int unsigned STATUS_DONE_BIT  = 0;
    localparam int unsigned STATUS_ERR_BIT   = 1;
    localparam int unsigned STATUS_COUNT_LSB = 16;
    localparam int unsigned STATUS_COUNT_W   = 16;
    localparam int unsigned STATUS_W         = 32;

    // {count, 14'b0, err, done=1}
    function automatic logic [STATUS_W-1:0] build_status(input logic [STATUS_COUNT_W-1:0] count,
                                                         input logic                      err);
        logic [STATUS_W-1:0] s;
        s = '0;
        s[STATUS_COUNT_LSB +: STATUS_COUNT_W] = count;
        s[STATUS_ERR_BIT]                     = err;
        s[STATUS_DONE_BIT]                    = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/mem_addr_check.sv
// Combinational legality check for a block request.
//   address : base cell address of the block
//   write   : 1 for a block write
//   err_c   : block runs past the end of memory, or a write touches a reserved word
module mem_addr_check
    import coproc_mem_pkg::*;
#(
    parameter int unsigned size     = 1024,
    parameter int unsigned blocks   = 4,
    parameter int unsigned log_size = 10
) (
    input  logic [log_size-1:0] address,
    input  logic                write,
    output logic                err_c
);

    localparam int unsigned EXT_W = log_size + 1;

    logic [EXT_W-1:0] end_addr;
    logic             range_err;
    logic             reserved_err;

    // One extra bit so address+blocks cannot wrap past the top of memory
    assign end_addr     = {1'b0, address} + EXT_W'(blocks);
    assign range_err    = end_addr > EXT_W'(size);
    assign reserved_err = write && (address < log_size'(RESERVED_WORDS));
    assign err_c        = range_err || reserved_err;

endmodule

// File: rtl/mem_master.sv
// Initiator side of the coprocessor word memory: accepts one block read/write
// request at a time, drives the memory strobes, and returns a response.
// Optional feature macro: MEM_MASTER_STATUS_UPDATE_EN inserts a STATUS state that
// writes {txn_count, 14'b0, err, 1} to the memory status port for every transaction.
// Ports:
//   in_clk, in_reset                      : clock, async active-low reset
//   in_req_*  / out_req_ready             : request channel (ready only in IDLE)
//   out_resp_* / in_resp_ready            : response channel (data, error flag)
//   out_mem_address/data/read_en/write_en : memory block port
//   in_mem_data                           : memory read data, one cycle after read_en
//   out_mem_status/out_mem_write_status_en: memory status port
module mem_master
    import coproc_mem_pkg::*;
#(
    parameter int unsigned size       = 1024,
    parameter int unsigned blocks     = 4,
    parameter int unsigned log_size   = 10,
    parameter int unsigned cell_width = 32,
    parameter int unsigned width      = blocks * cell_width
) (
    input  logic                  in_clk,
    input  logic                  in_reset,
    input  logic                  in_req_valid,
    output logic                  out_req_ready,
    input  logic                  in_req_write,
    input  logic [log_size-1:0]   in_req_address,
    input  logic [width-1:0]      in_req_data,
    output logic                  out_resp_valid,
    input  logic                  in_resp_ready,
    output logic [width-1:0]      out_resp_data,
    output logic                  out_resp_err,
    output logic [log_size-1:0]   out_mem_address,
    output logic [width-1:0]      out_mem_data,
    output logic                  out_mem_read_en,
    output logic                  out_mem_write_en,
    input  logic [width-1:0]      in_mem_data,
    output logic [cell_width-1:0] out_mem_status,
    output logic                  out_mem_write_status_en
);

`ifdef MEM_MASTER_STATUS_UPDATE_EN
    localparam state_t POST_STATE = ST_STATUS;
`else
    localparam state_t POST_STATE = ST_RESP;
`endif

    state_t              state_q, state_d;
    logic                wr_q, wr_d;
    logic                err_q, err_d;
    logic [log_size-1:0] addr_q, addr_d;
    logic [width-1:0]    wdata_q, wdata_d;
    logic [width-1:0]    rdata_q, rdata_d;
    logic                chk_err_c;

    logic                req_ready_d, resp_valid_d, resp_err_d;
    logic                mem_rd_d, mem_wr_d;
    logic [log_size-1:0] mem_addr_d;
    logic [width-1:0]    mem_data_d;

    mem_addr_check #(
        .size     (size),
        .blocks   (blocks),
        .log_size (log_size)
    ) u_addr_check (
        .address (in_req_address),
        .write   (in_req_write),
        .err_c   (chk_err_c)
    );

    // Next state, request latch and read capture
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (in_req_valid) begin
                    wr_d    = in_req_write;
                    err_d   = chk_err_c;
                    addr_d  = in_req_address;
                    wdata_d = in_req_data;
                    rdata_d = '0;
                    if (chk_err_c)         state_d = POST_STATE;
                    else if (in_req_write) state_d = ST_WRITE;
                    else                   state_d = ST_READ;
                end
            end
            ST_READ:    state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                rdata_d = in_mem_data;
                state_d = POST_STATE;
            end
            ST_WRITE:   state_d = POST_STATE;
            ST_STATUS:  state_d = ST_RESP;
            ST_RESP:    if (in_resp_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state so every output is a flop
    always_comb begin
        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
        resp_err_d   = (state_d == ST_RESP) && err_d;
        mem_rd_d     = (state_d == ST_READ);
        mem_wr_d     = (state_d == ST_WRITE);
        mem_addr_d   = (mem_rd_d || mem_wr_d) ? addr_d : '0;
        mem_data_d   = mem_wr_d ? wdata_d : '0;
    end

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state_q          <= ST_IDLE;
            wr_q             <= 1'b0;
            err_q            <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            rdata_q          <= '0;
            out_req_ready    <= 1'b1;
            out_resp_valid   <= 1'b0;
            out_resp_err     <= 1'b0;
            out_mem_read_en  <= 1'b0;
            out_mem_write_en <= 1'b0;
            out_mem_address  <= '0;
            out_mem_data     <= '0;
        end else begin
            state_q          <= state_d;
            wr_q             <= wr_d;
            err_q            <= err_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            rdata_q          <= rdata_d;
            out_req_ready    <= req_ready_d;
            out_resp_valid   <= resp_valid_d;
            out_resp_err     <= resp_err_d;
            out_mem_read_en  <= mem_rd_d;
            out_mem_write_en <= mem_wr_d;
            out_mem_address  <= mem_addr_d;
            out_mem_data     <= mem_data_d;
        end
    end

    // Captured read data is cleared on accept, so writes and errors return 0
    assign out_resp_data = rdata_q;

`ifdef MEM_MASTER_STATUS_UPDATE_EN
    logic [STATUS_COUNT_W-1:0] count_q, count_d;
    logic                      status_en_d;
    logic [cell_width-1:0]     status_d;

    // Counter advances on entry to STATUS; the status word carries the new value
    always_comb begin
        status_en_d = (state_d == ST_STATUS);
        count_d     = count_q;
        status_d    = '0;
        if (status_en_d) begin
            count_d  = STATUS_COUNT_W'(count_q + STATUS_COUNT_W'(1));
            status_d = cell_width'(build_status(count_d, err_d));
        end
    end

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            count_q                 <= '0;
            out_mem_status          <= '0;
            out_mem_write_status_en <= 1'b0;
        end else begin
            count_q                 <= count_d;
            out_mem_status          <= status_d;
            out_mem_write_status_en <= status_en_d;
        end
    end
`else
    assign out_mem_status          = '0;
    assign out_mem_write_status_en = 1'b0;
`endif

endmodule

// File: tb/tb_mem_master.sv
module tb_mem_master;

    localparam int unsigned W  = 128;
    localparam int unsigned AW = 10;
`ifdef MEM_MASTER_STATUS_UPDATE_EN
    localparam int XL = 1;
`else
    localparam int XL = 0;
`endif

    logic          in_clk = 1'b0;
    logic          in_reset = 1'b0;
    logic          in_req_valid = 1'b0;
    logic          out_req_ready;
    logic          in_req_write = 1'b0;
    logic [AW-1:0] in_req_address = '0;
    logic [W-1:0]  in_req_data = '0;
    logic          out_resp_valid;
    logic          in_resp_ready = 1'b1;
    logic [W-1:0]  out_resp_data;
    logic          out_resp_err;
    logic [AW-1:0] out_mem_address;
    logic [W-1:0]  out_mem_data;
    logic          out_mem_read_en;
    logic          out_mem_write_en;
    logic [W-1:0]  in_mem_data;
    logic [31:0]   out_mem_status;
    logic          out_mem_write_status_en;

    mem_master dut (
        .in_clk                  (in_clk),
        .in_reset                (in_reset),
        .in_req_valid            (in_req_valid),
        .out_req_ready           (out_req_ready),
        .in_req_write            (in_req_write),
        .in_req_address          (in_req_address),
        .in_req_data             (in_req_data),
        .out_resp_valid          (out_resp_valid),
        .in_resp_ready           (in_resp_ready),
        .out_resp_data           (out_resp_data),
        .out_resp_err            (out_resp_err),
        .out_mem_address         (out_mem_address),
        .out_mem_data            (out_mem_data),
        .out_mem_read_en         (out_mem_read_en),
        .out_mem_write_en        (out_mem_write_en),
        .in_mem_data             (in_mem_data),
        .out_mem_status          (out_mem_status),
        .out_mem_write_status_en (out_mem_write_status_en)
    );

    always #5 in_clk = ~in_clk;

    int cyc = 0;
    always @(posedge in_clk) cyc <= cyc + 1;

    // Memory model: 1-cycle registered read, garbage on the bus when not reading
    logic [31:0] mem [1024];
    logic        rvalid;
    logic [W-1:0] rdata;
    always @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hC000_0000 | 32'(i);
        end else begin
            rvalid <= out_mem_read_en;
            if (out_mem_read_en)
                for (int i = 0; i < 4; i++) rdata[32*i +: 32] <= mem[AW'(32'(out_mem_address) + i)];
            if (out_mem_write_en)
                for (int i = 0; i < 4; i++) mem[AW'(32'(out_mem_address) + i)] <= out_mem_data[32*i +: 32];
        end
    end
    assign in_mem_data = rvalid ? rdata : 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct {
        logic         err;
        logic [W-1:0] data;
        int           acc;
        int           lat;
        int           rd;
        int           wr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] stq[$];
    int          txn_n = 0;

    // Monitor: strobe rules every cycle, response compare on each handshake
    int   rd_cnt = 0, wr_cnt = 0, st_cnt = 0, vstart = 0;
    logic prev_valid = 1'b0;
    always @(negedge in_clk) begin
        if (!in_reset) begin
            rd_cnt = 0; wr_cnt = 0; st_cnt = 0; prev_valid = 1'b0;
        end else begin
            if (out_mem_read_en)  rd_cnt++;
            if (out_mem_write_en) wr_cnt++;
            if (out_mem_read_en && out_mem_write_en) chk("strobe_overlap", 128'd1, 128'd0);
            if (!out_mem_read_en && !out_mem_write_en) begin
                chk("idle_mem_addr", W'(out_mem_address), '0);
                chk("idle_mem_data", out_mem_data, '0);
            end
`ifdef MEM_MASTER_STATUS_UPDATE_EN
            if (out_mem_write_status_en) begin
                st_cnt++;
                if (stq.size() == 0) chk("unexpected_status", 128'd1, 128'd0);
                else chk("status_word", W'(out_mem_status), W'(stq.pop_front()));
            end
`else
            if (out_mem_write_status_en || out_mem_status != 32'd0) chk("status_tied", 128'd1, 128'd0);
`endif
            if (out_resp_valid && !prev_valid) vstart = cyc;
            prev_valid = out_resp_valid;
            if (out_resp_valid && in_resp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 128'd1, 128'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_err", W'(out_resp_err), W'(e.err));
                    chk("resp_data", out_resp_data, e.data);
                    chk("resp_latency", W'(vstart - e.acc), W'(e.lat));
                    chk("read_strobes", W'(rd_cnt), W'(e.rd));
                    chk("write_strobes", W'(wr_cnt), W'(e.wr));
`ifdef MEM_MASTER_STATUS_UPDATE_EN
                    chk("status_strobes", W'(st_cnt), 128'd1);
`endif
                end
                rd_cnt = 0; wr_cnt = 0; st_cnt = 0;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!out_req_ready && n < 50) begin @(negedge in_clk); n++; end
        if (!out_req_ready) chk("ready_timeout", 128'd0, 128'd1);
    endtask

    task automatic push_exp(input logic wr, input logic ee, input logic [W-1:0] ed);
        exp_t e;
        e.err  = ee;
        e.data = ee ? '0 : ed;
        e.acc  = cyc + 1;
        e.lat  = (ee ? 0 : (wr ? 1 : 2)) + XL;
        e.rd   = (!wr && !ee) ? 1 : 0;
        e.wr   = (wr && !ee) ? 1 : 0;
        sb.push_back(e);
        txn_n++;
        stq.push_back({16'(txn_n), 14'b0, ee, 1'b1});
    endtask

    // Issue one request (called at a negedge); returns at the negedge after acceptance
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d,
                         input logic ee, input logic [W-1:0] ed, input bit push);
        wait_ready();
        in_req_write   = wr;
        in_req_address = a;
        in_req_data    = d;
        in_req_valid   = 1'b1;
        if (push) push_exp(wr, ee, ed);
        @(posedge in_clk);
        @(negedge in_clk);
        in_req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin @(negedge in_clk); n++; end
        if (sb.size() != 0) begin
            chk("resp_timeout", W'(sb.size()), '0);
            sb.delete();
        end
    endtask

    localparam logic [W-1:0] D8   = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    localparam logic [W-1:0] D1020 = 128'h8888_8888_7777_7777_6666_6666_5555_5555;
    localparam logic [W-1:0] D12  = 128'hFFFF_0000_EEEE_1111_DDDD_2222_CCCC_3333;
    localparam logic [W-1:0] D0   = 128'hC000_0003_C000_0002_C000_0001_C000_0000;

    initial begin
        logic [W-1:0] held;
        int n;
        // Reset values
        repeat (2) @(negedge in_clk);
        chk("rst_req_ready", W'(out_req_ready), 128'd1);
        chk("rst_resp_valid", W'(out_resp_valid), 128'd0);
        chk("rst_strobes", W'({out_mem_read_en, out_mem_write_en, out_mem_write_status_en}), 128'd0);
        chk("rst_resp_data", out_resp_data, '0);
        in_reset = 1'b1;
        @(negedge in_clk);

        // Reset in the READ cycle: discarded, no response
        issue(1'b0, 10'd8, '0, 1'b0, '0, 1'b0);
        chk("midread_strobe_seen", W'(out_mem_read_en), 128'd1);
        in_reset = 1'b0;
        #1;
        chk("midread_rd_en", W'(out_mem_read_en), 128'd0);
        chk("midread_addr", W'(out_mem_address), '0);
        chk("midread_resp_valid", W'(out_resp_valid), 128'd0);
        txn_n = 0;
        stq.delete();
        repeat (2) @(negedge in_clk);
        in_reset = 1'b1;
        repeat (6) @(negedge in_clk);
        chk("midread_ready_after", W'(out_req_ready), 128'd1);

        // Write then read back
        issue(1'b1, 10'd8, D8, 1'b0, '0, 1'b1);   drain();
        issue(1'b0, 10'd8, '0, 1'b0, D8, 1'b1);   drain();
        // Range boundaries
        issue(1'b0, 10'd1021, '0, 1'b1, '0, 1'b1); drain();
        issue(1'b1, 10'd1020, D1020, 1'b0, '0, 1'b1); drain();
        issue(1'b0, 10'd1020, '0, 1'b0, D1020, 1'b1); drain();
        issue(1'b0, 10'd1023, '0, 1'b1, '0, 1'b1); drain();
        // Reserved words
        issue(1'b1, 10'd1, D8, 1'b1, '0, 1'b1);    drain();
        issue(1'b1, 10'd0, D8, 1'b1, '0, 1'b1);    drain();
        issue(1'b0, 10'd0, '0, 1'b0, D0, 1'b1);    drain();
        issue(1'b0, 10'd1, '0, 1'b0, {32'hC000_0004, D0[127:32]}, 1'b1); drain();

        // Response backpressure with a second request held on the channel
        @(posedge in_clk); #1 in_resp_ready = 1'b0;
        @(negedge in_clk);
        issue(1'b0, 10'd8, '0, 1'b0, D8, 1'b1);
        n = 0;
        while (!out_resp_valid && n < 20) begin @(negedge in_clk); n++; end
        chk("bp_valid_seen", W'(out_resp_valid), 128'd1);
        held = out_resp_data;
        in_req_write   = 1'b1;
        in_req_address = 10'd12;
        in_req_data    = D12;
        in_req_valid   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge in_clk);
            chk("bp_valid_hold", W'(out_resp_valid), 128'd1);
            chk("bp_data_hold", out_resp_data, held);
            chk("bp_ready_low", W'(out_req_ready), 128'd0);
        end
        @(posedge in_clk); #1 in_resp_ready = 1'b1;
        n = 0;
        do begin @(negedge in_clk); n++; end while (!out_req_ready && n < 20);
        chk("bp_accept_delay", W'(n), 128'd2);
        push_exp(1'b1, 1'b0, '0);
        @(posedge in_clk);
        @(negedge in_clk);
        in_req_valid = 1'b0;
        drain();
        issue(1'b0, 10'd12, '0, 1'b0, D12, 1'b1); drain();

        repeat (3) @(negedge in_clk);
`ifdef MEM_MASTER_STATUS_UPDATE_EN
        chk("status_queue_empty", W'(stq.size()), '0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
